// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: selectable bitwise gate on WIDTH-bit operands, registered
// through a one-deep valid/ready stage with optional result accumulation,
// reduction flags on the registered result and an accepted-bundle counter.
//
// Handshake: a bundle transfers on a clk edge where in_valid && in_ready;
// a result transfers on a clk edge where out_valid && out_ready. in_ready is
// !out_valid || out_ready, so a full stage drained this cycle refills on the
// same edge. The producer must hold its bundle stable while in_ready=0.
module logic_unit_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    input  logic               acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               y_and,
    output logic               y_or,
    output logic               y_xor,
    output logic [COUNT_W-1:0] txn_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   accum_q, accum_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH-1:0]   opnd_a;
    logic [WIDTH-1:0]   result;

    // Stage can take a bundle when empty or when the held result leaves now.
    assign in_ready = (state_q == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    // Gate function; operand A comes from the accumulator in chained mode.
    always_comb begin
        opnd_a = acc ? accum_q : a;
        result = '0;
        case (op)
            OP_AND:  result = opnd_a & b;
            OP_OR:   result = opnd_a | b;
            OP_NAND: result = ~(opnd_a & b);
            OP_NOR:  result = ~(opnd_a | b);
            OP_XOR:  result = opnd_a ^ b;
            OP_XNOR: result = ~(opnd_a ^ b);
            OP_NOT:  result = ~opnd_a;
            default: result = opnd_a;
        endcase
    end

    // Next-state: accept loads a new result (even while draining), a
    // consume without accept empties the stage, otherwise everything holds.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        accum_d = accum_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = ST_FULL;
            y_d     = result;
            accum_d = result;
            cnt_d   = cnt_q + COUNT_W'(1);
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Registers; reset discards any in-flight result and clears the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            accum_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            accum_q <= accum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign y         = y_q;
    assign y_and     = &y_q;
    assign y_or      = |y_q;
    assign y_xor     = ^y_q;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, COUNT_W=4): vector table for
// the op sweep and accumulate chain, plus hand sequences for backpressure,
// reset during a held result and counter wrap.
module tb_logic_unit_pipe;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         op;
    logic               acc;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   y;
    logic               y_and;
    logic               y_or;
    logic               y_xor;
    logic [COUNT_W-1:0] txn_count;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0]       op;
        logic             acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_y;
        logic             exp_and;
        logic             exp_or;
        logic             exp_xor;
    } vec_t;

    vec_t vecs[12];

    logic_unit_pipe #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_and     (y_and),
        .y_or      (y_or),
        .y_xor     (y_xor),
        .txn_count (txn_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic ac,
                         input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                         input logic ordy);
        in_valid  = v;
        op        = o;
        acc       = ac;
        a         = aa;
        b         = bb;
        out_ready = ordy;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //            op    acc   a      b      y      and   or    xor
        vecs[0]  = '{3'd0, 1'b0, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'd1, 1'b0, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'd2, 1'b0, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'd3, 1'b0, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'd4, 1'b0, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'd5, 1'b0, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'd6, 1'b0, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'd7, 1'b0, 8'hA5, 8'h0F, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd4, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{3'd4, 1'b1, 8'hFF, 8'h02, 8'h03, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'd4, 1'b1, 8'hFF, 8'h04, 8'h07, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{3'd7, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0, 1'b1, 1'b1};

        // Reset held two cycles while a bundle is offered
        rst = 1'b1;
        drive(1'b1, 3'd1, 1'b0, 8'hFF, 8'hFF, 1'b0);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'h00);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_txn_count", 32'(txn_count), 32'd0);
        chk("rst_y_and", 32'(y_and), 32'd0);
        chk("rst_y_or", 32'(y_or), 32'd0);
        chk("rst_y_xor", 32'(y_xor), 32'd0);

        // Op sweep then accumulate chain, back-to-back with out_ready=1
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].acc, vecs[i].a, vecs[i].b, 1'b1);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_y_and", i), 32'(y_and), 32'(vecs[i].exp_and));
            chk($sformatf("vec%0d_y_or", i), 32'(y_or), 32'(vecs[i].exp_or));
            chk($sformatf("vec%0d_y_xor", i), 32'(y_xor), 32'(vecs[i].exp_xor));
            if (i == 7) chk("sweep_txn_count", 32'(txn_count), 32'd8);
        end
        chk("chain_txn_count", 32'(txn_count), 32'd12);

        // Consume only: stage empties, y and count hold
        drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
        step();
        chk("consume_out_valid", 32'(out_valid), 32'd0);
        chk("consume_y_hold", 32'(y), 32'h10);
        chk("consume_txn_count", 32'(txn_count), 32'd12);

        // Backpressure: X accepted into empty stage, Y blocked for 3 cycles
        drive(1'b1, 3'd4, 1'b0, 8'hF0, 8'hFF, 1'b0);
        step();
        chk("bp_x_y", 32'(y), 32'h0F);
        chk("bp_x_txn_count", 32'(txn_count), 32'd13);
        drive(1'b1, 3'd0, 1'b0, 8'hFF, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
            step();
            chk($sformatf("bp_hold%0d_y", i), 32'(y), 32'h0F);
            chk($sformatf("bp_hold%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_txn_count", i), 32'(txn_count), 32'd13);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_y_after_release", 32'(y), 32'h3C);
        chk("bp_out_valid_after_release", 32'(out_valid), 32'd1);
        chk("bp_txn_count_after_release", 32'(txn_count), 32'd14);
        drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
        step();
        chk("bp_drain_out_valid", 32'(out_valid), 32'd0);
        chk("bp_drain_y_hold", 32'(y), 32'h3C);

        // Reset while a result is held under backpressure
        drive(1'b1, 3'd7, 1'b0, 8'h55, 8'h00, 1'b0);
        step();
        chk("mid_held_y", 32'(y), 32'h55);
        chk("mid_held_out_valid", 32'(out_valid), 32'd1);
        chk("mid_held_txn_count", 32'(txn_count), 32'd15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_y", 32'(y), 32'h00);
        chk("mid_rst_txn_count", 32'(txn_count), 32'd0);
        drive(1'b1, 3'd1, 1'b1, 8'hFF, 8'h00, 1'b1);
        step();
        chk("mid_acc_cleared_y", 32'(y), 32'h00);
        chk("mid_acc_out_valid", 32'(out_valid), 32'd1);
        chk("mid_acc_txn_count", 32'(txn_count), 32'd1);

        // Counter wrap: 16 more accepts makes 17 since reset
        for (int i = 2; i <= 17; i++) begin
            drive(1'b1, 3'd7, 1'b0, 8'(i), 8'h00, 1'b1);
            step();
            chk($sformatf("wrap%0d_y", i), 32'(y), 32'(i));
            if (i == 15) chk("wrap_all_ones", 32'(txn_count), 32'hF);
            if (i == 16) chk("wrap_zero", 32'(txn_count), 32'h0);
        end
        chk("wrap_txn_count", 32'(txn_count), 32'd1);
        drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("wrap_consume%0d_txn_count", i), 32'(txn_count), 32'd1);
        end
        chk("wrap_consume_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        #1;
        chk("empty_in_ready_no_out_ready", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
